// File: rtl/fib_sequencer_if.sv
// rtl/fib_sequencer_if.sv - command/status bundle between register block and fib_sequencer
interface fib_sequencer_if #(
    parameter int WIDTH = 30,
    parameter int NW    = 6
);
    logic             start_i;
    logic [NW-1:0]    n_i;
    logic             abort_i;
    logic             irq_ack_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] result_o;
    logic             overflow_o;
    logic             irq_o;

    modport master (
        output start_i, n_i, abort_i, irq_ack_i,
        input  busy_o, done_o, result_o, overflow_o, irq_o
    );

    modport slave (
        input  start_i, n_i, abort_i, irq_ack_i,
        output busy_o, done_o, result_o, overflow_o, irq_o
    );
endinterface

// File: rtl/fib_sequencer.sv
// rtl/fib_sequencer.sv - run controller: clear, step N times, track wrap, latch F(n)
module fib_sequencer #(
    parameter int WIDTH = 30,
    parameter int NW    = 6
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    fib_sequencer_if.slave   ctl,
    input  logic [WIDTH-1:0] fib_value_i,
    output logic             fib_clr_o,
    output logic             fib_step_o
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STEP,
        S_WAIT,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [NW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             overflow_q, overflow_d;
    logic             irq_q, irq_d;
    logic             wrap;

    // A sum smaller than one of its addends can only come from a wrap.
    assign wrap = (fib_value_i < prev_q);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            prev_q     <= '0;
            ovf_q      <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            prev_q     <= prev_d;
            ovf_q      <= ovf_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
            irq_q      <= irq_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        prev_d     = prev_q;
        ovf_d      = ovf_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        irq_d      = irq_q;

        case (state_q)
            S_IDLE: begin
                if (ctl.start_i && !ctl.abort_i) begin
                    cnt_d   = ctl.n_i;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                prev_d = '0;
                ovf_d  = 1'b0;
                if (ctl.abort_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d    = S_DONE;
                    result_d   = '0;
                    overflow_d = 1'b0;
                end else begin
                    state_d = S_STEP;
                end
            end
            S_STEP: begin
                state_d = ctl.abort_i ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (ctl.abort_i) begin
                    state_d = S_IDLE;
                end else begin
                    prev_d = fib_value_i;
                    ovf_d  = ovf_q | wrap;
                    cnt_d  = cnt_q - NW'(1);
                    if (cnt_q == NW'(1)) begin
                        state_d    = S_DONE;
                        result_d   = fib_value_i;
                        overflow_d = ovf_q | wrap;
                    end else begin
                        state_d = S_STEP;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Set on DONE entry takes priority over a simultaneous acknowledge.
        if (ctl.irq_ack_i) begin
            irq_d = 1'b0;
        end
        if (state_d == S_DONE && state_q != S_DONE) begin
            irq_d = 1'b1;
        end
    end

    assign fib_clr_o      = (state_q == S_CLEAR);
    assign fib_step_o     = (state_q == S_STEP);
    assign ctl.busy_o     = (state_q != S_IDLE);
    assign ctl.done_o     = (state_q == S_DONE);
    assign ctl.result_o   = result_q;
    assign ctl.overflow_o = overflow_q;
    assign ctl.irq_o      = irq_q;
endmodule

// File: tb/tb_fib_sequencer.sv
// tb/tb_fib_sequencer.sv - self-checking bench for fib_sequencer with a behavioural datapath
module tb_fib_sequencer;
    localparam int WIDTH = 30;
    localparam int NW    = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [WIDTH-1:0] dp_val;
    logic [WIDTH-1:0] dp_prev;
    logic             fib_clr;
    logic             fib_step;

    fib_sequencer_if #(.WIDTH(WIDTH), .NW(NW)) bus();

    fib_sequencer #(.WIDTH(WIDTH), .NW(NW)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .ctl         (bus),
        .fib_value_i (dp_val),
        .fib_clr_o   (fib_clr),
        .fib_step_o  (fib_step)
    );

    // Datapath: clear makes the next term 0 with a hidden predecessor of 1.
    always @(posedge clk) begin
        if (fib_clr) begin
            dp_val  <= '0;
            dp_prev <= WIDTH'(1);
        end else if (fib_step) begin
            dp_val  <= dp_val + dp_prev;
            dp_prev <= dp_val;
        end
    end

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             ov;
    } exp_t;

    typedef struct {
        int               n;
        logic [WIDTH-1:0] res;
        logic             ov;
    } vec_t;

    exp_t             sb_q[$];
    int               n_chk  = 0;
    int               n_fail = 0;
    logic [WIDTH-1:0] last_res = '0;
    logic             last_ov  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint fib_model(input int n);
        longint a = 0;
        longint b = 1;
        longint t;
        for (int i = 0; i < n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.done_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                check("result", 64'(bus.result_o), 64'(e.res));
                check("overflow", 64'(bus.overflow_o), 64'(e.ov));
                check("irq_at_done", 64'(bus.irq_o), 64'd1);
            end
        end
    end

    task automatic run(input int n, input int abort_cyc, input int mid_start_cyc, input int ack_cyc);
        bit               aborted;
        int               last;
        longint           f;
        logic [WIDTH-1:0] er;
        logic             eo;
        logic             e_busy, e_clr, e_step, e_done;
        aborted = (abort_cyc > 0) && (abort_cyc < 2 * n + 2);
        f  = fib_model(n);
        er = f[WIDTH-1:0];
        eo = (f >= (64'd1 << WIDTH));
        if (!aborted) sb_q.push_back('{er, eo});
        last = aborted ? abort_cyc + 1 : 2 * n + 3;
        bus.start_i = 1'b1;
        bus.n_i     = NW'(n);
        @(posedge clk);
        #1;
        for (int cyc = 1; cyc <= last; cyc++) begin
            bus.start_i   = (cyc == mid_start_cyc);
            bus.abort_i   = (cyc == abort_cyc);
            bus.irq_ack_i = (ack_cyc > 0) && (cyc == ack_cyc || cyc == ack_cyc + 1);
            @(negedge clk);
            e_busy = aborted ? (cyc <= abort_cyc) : (cyc <= 2 * n + 2);
            e_clr  = (cyc == 1);
            e_step = (cyc >= 2) && (cyc <= 2 * n) && (cyc % 2 == 0) && (!aborted || cyc <= abort_cyc);
            e_done = !aborted && (cyc == 2 * n + 2);
            check($sformatf("n%0d_cyc%0d_busy_clr_step_done", n, cyc),
                  64'({bus.busy_o, fib_clr, fib_step, bus.done_o}),
                  64'({e_busy, e_clr, e_step, e_done}));
            if (cyc < last) begin
                @(posedge clk);
                #1;
            end
        end
        bus.start_i   = 1'b0;
        bus.abort_i   = 1'b0;
        bus.irq_ack_i = 1'b0;
        if (!aborted) begin
            last_res = er;
            last_ov  = eo;
        end else begin
            check("abort_keeps_result", 64'(bus.result_o), 64'(last_res));
            check("abort_keeps_overflow", 64'(bus.overflow_o), 64'(last_ov));
        end
        if (ack_cyc > 0) check("irq_cleared_by_late_ack", 64'(bus.irq_o), 64'd0);
    endtask

    task automatic ack_irq();
        bus.irq_ack_i = 1'b1;
        @(posedge clk);
        #1;
        bus.irq_ack_i = 1'b0;
        @(negedge clk);
        check("irq_ack_clears", 64'(bus.irq_o), 64'd0);
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{10, 30'd55,        1'b0};
        vecs[1] = '{0,  30'd0,         1'b0};
        vecs[2] = '{44, 30'd701408733, 1'b0};
        vecs[3] = '{45, 30'd61161346,  1'b1};
        vecs[4] = '{3,  30'd2,         1'b0};
        vecs[5] = '{1,  30'd1,         1'b0};
        vecs[6] = '{2,  30'd1,         1'b0};

        bus.start_i   = 1'b0;
        bus.n_i       = '0;
        bus.abort_i   = 1'b0;
        bus.irq_ack_i = 1'b0;
        #2;
        check("reset_outputs",
              64'({bus.busy_o, bus.done_o, fib_clr, fib_step, bus.overflow_o, bus.irq_o, bus.result_o}),
              64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run(vecs[i].n, 0, 0, 0);
            check($sformatf("table_result_n%0d", vecs[i].n), 64'(bus.result_o), 64'(vecs[i].res));
            check($sformatf("table_overflow_n%0d", vecs[i].n), 64'(bus.overflow_o), 64'(vecs[i].ov));
            ack_irq();
        end

        run(10, 7, 0, 0);
        check("abort_no_irq", 64'(bus.irq_o), 64'd0);
        run(3, 0, 0, 0);
        ack_irq();
        run(10, 0, 5, 0);
        run(2, 6, 0, 0);

        bus.start_i = 1'b1;
        bus.abort_i = 1'b1;
        bus.n_i     = NW'(5);
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        bus.abort_i = 1'b0;
        @(negedge clk);
        check("start_with_abort_busy", 64'(bus.busy_o), 64'd0);
        @(negedge clk);
        check("start_with_abort_busy_later", 64'(bus.busy_o), 64'd0);

        run(2, 0, 0, 5);

        for (int i = 0; i < 3; i++) begin
            run(int'($urandom_range(0, 63)), 0, 0, 0);
        end
        run(7, 0, 0, 0);

        bus.start_i = 1'b1;
        bus.n_i     = NW'(20);
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        repeat (6) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("reset_mid_run_outputs",
              64'({bus.busy_o, bus.done_o, fib_clr, fib_step, bus.overflow_o, bus.irq_o, bus.result_o}),
              64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_after_reset", 64'(bus.busy_o), 64'd0);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fib_sequencer.md
# fib_sequencer

- Run controller for the Fibonacci datapath.
- Accepts a "compute term N" command, clears the generator, issues N single-term step strobes, watches each new term for wrap-around, then latches the result.
- Signals completion with a done pulse and a sticky interrupt.
- Sits between the Wishbone register block and the Fibonacci generator.

## Interface

Parameters:
- WIDTH, 30: datapath width of fib_value_i and result_o.
- NW, 6: width of the term-count input n_i.

Ports:
- wb_clk_i  input  1  single clock; all state changes on its rising edge.
- wb_rst_i  input  1  reset, asynchronous and active-high.
- start_i  input  1  run request; sampled only in IDLE.
- n_i  input  NW  target term index; captured with start_i.
- abort_i  input  1  cancels a run in progress.
- irq_ack_i  input  1  clears irq_o.
- fib_value_i  input  WIDTH  current term from the datapath.
- fib_clr_o  output  1  datapath clear strobe; the next term after it is F(0)=0.
- fib_step_o  output  1  datapath advance strobe, one term per cycle high.
- busy_o  output  1  high in every state except IDLE.
- done_o  output  1  one-cycle completion pulse.
- result_o  output  WIDTH  F(n) mod 2^WIDTH from the last completed run.
- overflow_o  output  1  last completed run wrapped at least once.
- irq_o  output  1  completion interrupt, level until acknowledged.

## Operation

Datapath contract:
- fib_clr_o high in cycle c gives fib_value_i = 0 in cycle c+1.
- fib_step_o high in cycle c gives fib_value_i = old prev + old value (mod 2^WIDTH) in cycle c+1.
- The sequence is 0, 1, 1, 2, 3, 5, …

Registers:
- cnt: NW-bit remaining-step counter.
- prev: WIDTH-bit copy of the previous term.
- ovf: internal sticky wrap flag.

States:
- IDLE: outputs idle. On start_i and not abort_i, load cnt = n_i and go to CLEAR.
- CLEAR: fib_clr_o = 1. Clear prev and ovf. If cnt == 0 go to DONE, else go to STEP.
- STEP: fib_step_o = 1. Go to WAIT.
- WAIT:
  - Sample fib_value_i.
  - If fib_value_i < prev, set ovf. This is the exact wrap test for an unsigned add.
  - Load prev = fib_value_i and decrement cnt.
  - If cnt becomes 0 go to DONE, else go to STEP.
- DONE: done_o = 1. Go to IDLE.

Result and interrupt:
- result_o and overflow_o load on the edge entering DONE: result_o takes fib_value_i (0 for n = 0), overflow_o takes ovf. Both hold until the next completed run.
- irq_o sets on the edge entering DONE. irq_ack_i clears it. A set in the same cycle as an ack wins.

Abort and start rules:
- abort_i in CLEAR, STEP or WAIT: go to IDLE on the next edge. No done_o, no irq. result_o and overflow_o keep their prior values. fib_step_o is low from that edge on.
- abort_i in DONE is ignored; the run completes.
- start_i while busy is ignored and is not queued.
- start_i together with abort_i in IDLE: abort wins, the start is dropped.

Width rules:
- n_i may be any value 0 to 2^NW−1.
- Terms past the wrap point keep accumulating mod 2^WIDTH.
- ovf stays set once set.

## Timing

- Reset values (asynchronous, immediate): state IDLE, busy_o 0, done_o 0, fib_clr_o 0, fib_step_o 0, result_o 0, overflow_o 0, irq_o 0, cnt 0, prev 0.
- Take start sampled at edge 0 as cycle 0:
  - busy_o rises in cycle 1, with CLEAR in cycle 1.
  - STEP occurs in cycles 2, 4, …, 2n; WAIT in cycles 3, 5, …, 2n+1.
  - done_o is high in cycle 2n+2.
  - busy_o falls in cycle 2n+3, which is the earliest cycle a new start is accepted.
- n = 0: done_o in cycle 2.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset asserted mid-run returns to IDLE immediately, discards the run, and clears result_o, overflow_o and irq_o.

## Test plan

- Reset then start n=10: fib_step_o pulses in cycles 2 through 20 (even cycles only), done_o in cycle 22, result_o=55, overflow_o=0, irq_o=1.
- n=0: fib_clr_o in cycle 1, no fib_step_o, done_o in cycle 2, result_o=0, overflow_o=0.
- n=44 then n=45 (WIDTH=30):
  - n=44: result_o=701408733, overflow_o=0.
  - n=45: result_o=61161346, overflow_o=1.
  - Then n=3: result_o=2, overflow_o=0, showing ovf cleared at CLEAR.
- Start n=10, abort_i in cycle 7:
  - IDLE from cycle 8, busy_o=0, no done_o.
  - result_o and irq_o keep their prior values.
  - A fresh start is accepted in the following cycle.
- start_i pulsed in cycle 5 of a busy run: ignored, no second done_o. start_i with abort_i in IDLE: busy_o stays 0.
- irq handshake: irq_ack_i high in the same cycle the edge enters DONE keeps irq_o=1; irq_ack_i the cycle after clears it. wb_rst_i asserted mid-run clears all outputs asynchronously.
